aes_ctr_core: RTL and testbench

- Iterative, parametrised AES-CTR keystream engine supporting AES-128, AES-192 and AES-256.
- Computes one round per clock and generates a programmed number of consecutive counter blocks from one start command.
- Delivers each block over a valid/ready output port.
- Sits between the key-schedule storage, which supplies round keys via an indexed lookup port, and the CTR datapath; it is the successor to the fixed AES-256 single-block encryption top.

---
 rtl/aes_ctr_core_if.sv | 37 +++
 rtl/aes_ctr_core.sv | 162 ++++++++++++++++
 tb/tb_aes_ctr_core.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ctr_core_if.sv
// Command, round-key lookup and keystream output signals of aes_ctr_core.
// The plaintext channel exists only when AES_CTR_PT_XOR_EN is defined.
interface aes_ctr_core_if;
  logic         start_i;
  logic [127:0] iv_i;
  logic [15:0]  blocks_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] out_o;
  logic         busy_o;
  logic         done_o;
`ifdef AES_CTR_PT_XOR_EN
  logic [127:0] pt_i;
  logic         pt_valid_i;
  logic         pt_ready_o;

  modport master (
    output start_i, iv_i, blocks_i, rk_i, out_ready_i, pt_i, pt_valid_i,
    input  rk_idx_o, out_valid_o, out_o, busy_o, done_o, pt_ready_o
  );
  modport slave (
    input  start_i, iv_i, blocks_i, rk_i, out_ready_i, pt_i, pt_valid_i,
    output rk_idx_o, out_valid_o, out_o, busy_o, done_o, pt_ready_o
  );
`else
  modport master (
    output start_i, iv_i, blocks_i, rk_i, out_ready_i,
    input  rk_idx_o, out_valid_o, out_o, busy_o, done_o
  );
  modport slave (
    input  start_i, iv_i, blocks_i, rk_i, out_ready_i,
    output rk_idx_o, out_valid_o, out_o, busy_o, done_o
  );
`endif
endinterface

// File: rtl/aes_ctr_core.sv
// Iterative AES-128/192/256 CTR keystream engine, one round per clock.
// Define AES_CTR_PT_XOR_EN to XOR a plaintext stream into the output.
module aes_ctr_core #(
  parameter int KEY_BITS = 256,
  parameter int CTR_W    = 32
) (
  input logic           clk,
  input logic           rst,
  aes_ctr_core_if.slave bus
);
  localparam int NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;
  localparam logic [127:0] CTR_MASK =
    (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, OUT} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      m[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return m;
  endfunction

  state_e       state, state_next;
  logic [127:0] ctr, st, ks;
  logic [127:0] ss, round_data, final_data;
  logic [15:0]  rem;
  logic [3:0]   round;
  logic         done_q;
  logic         xfer;

  // NOTE: combinational blocks use blocking '=', clocked blocks use '<=' so every flop samples pre-edge values.
  always_comb begin
    ss         = sub_shift(st);
    round_data = mix_columns(ss) ^ bus.rk_i;
    final_data = ss ^ bus.rk_i;
  end

`ifdef AES_CTR_PT_XOR_EN
  assign xfer = (state == OUT) && bus.out_ready_i && bus.pt_valid_i;
`else
  assign xfer = (state == OUT) && bus.out_ready_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    state_next = state;
    case (state)
      IDLE:    if (bus.start_i && bus.blocks_i != '0) state_next = INIT;
      INIT:    state_next = ROUND;
      ROUND:   if (round == 4'(NR - 1)) state_next = FINAL;
      FINAL:   state_next = OUT;
      OUT:     if (xfer) state_next = (rem == '0) ? IDLE : INIT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr    <= '0;
      rem    <= '0;
      round  <= '0;
      st     <= '0;
      ks     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start_i) begin
          ctr    <= bus.iv_i;
          rem    <= bus.blocks_i;
          done_q <= (bus.blocks_i == '0);
        end
        INIT: begin
          st    <= ctr ^ bus.rk_i;
          round <= 4'd1;
        end
        ROUND: begin
          st    <= round_data;
          round <= round + 4'd1;
        end
        FINAL: begin
          ks  <= final_data;
          ctr <= (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);
          rem <= rem - 16'd1;
        end
        OUT: if (xfer && rem == '0) done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state)
      ROUND:   bus.rk_idx_o = round;
      FINAL:   bus.rk_idx_o = 4'(NR);
      default: bus.rk_idx_o = 4'd0;
    endcase
    bus.busy_o = (state != IDLE);
    bus.done_o = done_q;
`ifdef AES_CTR_PT_XOR_EN
    bus.out_valid_o = (state == OUT) && bus.pt_valid_i;
    bus.pt_ready_o  = (state == OUT) && bus.out_ready_i;
    bus.out_o       = (state == OUT) ? (ks ^ bus.pt_i) : ks;
`else
    bus.out_valid_o = (state == OUT);
    bus.out_o       = ks;
`endif
  end
endmodule

// File: tb/tb_aes_ctr_core.sv
// Scoreboard bench for aes_ctr_core: AES-256 and AES-128 instances against a byte-matrix AES model.
module tb_aes_ctr_core;
  localparam logic [127:0] IV_KAT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KAT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_CTR_PT_XOR_EN
  localparam logic [127:0] PT_MASK = 128'h6bc1bee22e409f96e93d7e117393172a;
`else
  localparam logic [127:0] PT_MASK = '0;
`endif

  logic         clk, rst;
  int           checks, failures, done_cnt, done_cnt128;
  logic [7:0]   sbox [256];
  logic [31:0]  w [60];
  logic [127:0] rk256 [16];
  logic [127:0] rk128 [16];
  logic [127:0] exp_q [$];
  logic [127:0] exp_q128 [$];

  aes_ctr_core_if bus ();
  aes_ctr_core_if bus128 ();

  assign bus.rk_i    = rk256[bus.rk_idx_o];
  assign bus128.rk_i = rk128[bus128.rk_idx_o];

  aes_ctr_core #(.KEY_BITS(256), .CTR_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  aes_ctr_core #(.KEY_BITS(128), .CTR_W(32)) u_dut128 (.clk(clk), .rst(rst), .bus(bus128));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Table built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input bit to128);
    int         nr;
    logic [31:0] t;
    logic [7:0]  rc;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (to128) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else       rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] rk_of(input bit is128, input int i);
    return is128 ? rk128[i] : rk256[i];
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] blk, input bit is128);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] v;
    int           nr;
    nr = is128 ? 10 : 14;
    v  = blk ^ rk_of(is128, 0);
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = v[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (rnd == nr) ? t[r][c] :
                    gm(t[r][c], 8'h02) ^ gm(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) v[127-8*(4*c+r) -: 8] = s[r][c];
      v = v ^ rk_of(is128, rnd);
    end
    return v;
  endfunction

  task automatic start_cmd(input logic [127:0] iv, input logic [15:0] n, input bit on128);
    logic [127:0] ctr;
    ctr = iv;
    for (int k = 0; k < int'(n); k++) begin
      if (on128) exp_q128.push_back(model_enc(ctr, 1'b1) ^ PT_MASK);
      else       exp_q.push_back(model_enc(ctr, 1'b0) ^ PT_MASK);
      ctr[31:0] = ctr[31:0] + 32'd1;
    end
    if (on128) begin
      bus128.start_i = 1'b1; bus128.iv_i = iv; bus128.blocks_i = n;
    end else begin
      bus.start_i = 1'b1; bus.iv_i = iv; bus.blocks_i = n;
    end
    tick();
    bus.start_i    = 1'b0;
    bus128.start_i = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_hs);
    int n;
    n = 0;
    do begin
      if (rand_hs) begin
        bus.out_ready_i = 1'($urandom_range(0, 1));
`ifdef AES_CTR_PT_XOR_EN
        bus.pt_valid_i  = 1'($urandom_range(0, 1));
`endif
      end
      tick();
      n++;
    end while ((bus.busy_o || bus128.busy_o) && n < 3000);
    check("idle_within_budget", 128'(n < 3000), 128'd1);
    bus.out_ready_i = 1'b1;
`ifdef AES_CTR_PT_XOR_EN
    bus.pt_valid_i  = 1'b1;
`endif
    tick();
  endtask

  // Scoreboard monitors: the head of each queue must be on out_o whenever valid is high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o) begin
      check("expected_present_256", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        check(bus.out_ready_i ? "block_256" : "hold_256", bus.out_o, exp_q[0]);
        if (bus.out_ready_i) void'(exp_q.pop_front());
      end
    end
    if (!rst && bus.done_o) begin
      done_cnt++;
      check("done_with_idle_256", 128'(bus.busy_o), 128'd0);
    end
  end

  always @(negedge clk) begin
    if (!rst && bus128.out_valid_o) begin
      check("expected_present_128", 128'(exp_q128.size() != 0), 128'd1);
      if (exp_q128.size() != 0) begin
        check(bus128.out_ready_i ? "block_128" : "hold_128", bus128.out_o, exp_q128[0]);
        if (bus128.out_ready_i) void'(exp_q128.pop_front());
      end
    end
    if (!rst && bus128.done_o) done_cnt128++;
  end

  initial begin
    int cnt, d0, n_cmd;
    logic [15:0] nb;
    checks = 0; failures = 0; done_cnt = 0; done_cnt128 = 0;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.iv_i = '0; bus.blocks_i = '0; bus.out_ready_i = 1'b1;
    bus128.start_i = 1'b0; bus128.iv_i = '0; bus128.blocks_i = '0; bus128.out_ready_i = 1'b1;
`ifdef AES_CTR_PT_XOR_EN
    bus.pt_i = PT_MASK; bus.pt_valid_i = 1'b1;
    bus128.pt_i = PT_MASK; bus128.pt_valid_i = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin rk256[i] = '0; rk128[i] = '0; end
    build_sbox();
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b0);
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 1'b1);

    tick(); tick();
    check("rst_out_valid", 128'(bus.out_valid_o), 128'd0);
    check("rst_out", bus.out_o, 128'd0);
    check("rst_rk_idx", 128'(bus.rk_idx_o), 128'd0);
    check("rst_busy", 128'(bus.busy_o), 128'd0);
    check("rst_done", 128'(bus.done_o), 128'd0);
    rst = 1'b0;
    tick();

    // AES-256 known answer, latency and done timing.
    exp_q.push_back(KAT_256 ^ PT_MASK);
    bus.start_i = 1'b1; bus.iv_i = IV_KAT; bus.blocks_i = 16'd1;
    tick();
    bus.start_i = 1'b0;
    cnt = 1;
    while (!bus.out_valid_o && cnt < 100) begin tick(); cnt++; end
    check("latency_256", 128'(cnt), 128'd16);
    tick();
    check("done_after_xfer", 128'(bus.done_o), 128'd1);
    check("idle_at_done", 128'(bus.busy_o), 128'd0);
    tick();
    check("done_one_cycle", 128'(bus.done_o), 128'd0);

    // AES-128 known answer and latency.
    exp_q128.push_back(KAT_128 ^ PT_MASK);
    bus128.start_i = 1'b1; bus128.iv_i = IV_KAT; bus128.blocks_i = 16'd1;
    tick();
    bus128.start_i = 1'b0;
    cnt = 1;
    while (!bus128.out_valid_o && cnt < 100) begin tick(); cnt++; end
    check("latency_128", 128'(cnt), 128'd12);
    wait_idle(1'b0);
    check("done_count_128", 128'(done_cnt128), 128'd1);

    // Counter wrap of the low 32-bit field over three blocks.
    d0 = done_cnt;
    start_cmd({$urandom, $urandom, $urandom, 32'hffffffff}, 16'd3, 1'b0);
    wait_idle(1'b0);
    check("wrap_done_once", 128'(done_cnt - d0), 128'd1);

    // Backpressure: ten stalled cycles in OUT, then restart right after the transfer.
    bus.out_ready_i = 1'b0;
    start_cmd({$urandom, $urandom, $urandom, $urandom}, 16'd2, 1'b0);
    cnt = 0;
    while (!bus.out_valid_o && cnt < 100) begin tick(); cnt++; end
    for (int i = 0; i < 10; i++) begin
      check("stall_rk_idx", 128'(bus.rk_idx_o), 128'd0);
      check("stall_valid", 128'(bus.out_valid_o), 128'd1);
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    check("restart_busy", 128'(bus.busy_o), 128'd1);
    tick();
    check("restart_round1", 128'(bus.rk_idx_o), 128'd1);
    wait_idle(1'b0);

    // Zero-length command.
    d0 = done_cnt;
    start_cmd(IV_KAT, 16'd0, 1'b0);
    check("zero_len_done", 128'(bus.done_o), 128'd1);
    check("zero_len_busy", 128'(bus.busy_o), 128'd0);
    tick();
    check("zero_len_busy_after", 128'(bus.busy_o), 128'd0);
    check("zero_len_done_count", 128'(done_cnt - d0), 128'd1);

    // start_i while busy is ignored.
    start_cmd({$urandom, $urandom, $urandom, $urandom}, 16'd1, 1'b0);
    tick(); tick(); tick();
    bus.start_i = 1'b1; bus.iv_i = {$urandom, $urandom, $urandom, $urandom}; bus.blocks_i = 16'd5;
    tick();
    bus.start_i = 1'b0;
    wait_idle(1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("ignored_start_idle", 128'(bus.busy_o), 128'd0);
    check("ignored_start_queue", 128'(exp_q.size()), 128'd0);

`ifdef AES_CTR_PT_XOR_EN
    // Plaintext not yet valid: the block must wait.
    bus.pt_valid_i = 1'b0;
    start_cmd({$urandom, $urandom, $urandom, $urandom}, 16'd1, 1'b0);
    cnt = 0;
    while (!bus.pt_ready_o && cnt < 100) begin tick(); cnt++; end
    for (int i = 0; i < 5; i++) begin
      check("pt_wait_no_valid", 128'(bus.out_valid_o), 128'd0);
      check("pt_wait_busy", 128'(bus.busy_o), 128'd1);
      tick();
    end
    bus.pt_valid_i = 1'b1;
    wait_idle(1'b0);
`endif

    // Randomised commands with random handshake.
    d0 = done_cnt;
    n_cmd = 0;
    for (int i = 0; i < 6; i++) begin
      nb = 16'($urandom_range(1, 3));
      start_cmd({$urandom, $urandom, $urandom,
                 (i % 2 == 0) ? 32'hffffffff - 32'($urandom_range(0, 1)) : $urandom}, nb, 1'b0);
      wait_idle(1'b1);
      n_cmd++;
    end
    check("random_done_count", 128'(done_cnt - d0), 128'(n_cmd));

    // Reset in the middle of ROUND aborts without done_o.
    start_cmd({$urandom, $urandom, $urandom, $urandom}, 16'd2, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_round_idx", 128'(bus.rk_idx_o), 128'd5);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(bus.out_valid_o), 128'd0);
    check("abort_out", bus.out_o, 128'd0);
    check("abort_rk_idx", 128'(bus.rk_idx_o), 128'd0);
    check("abort_busy", 128'(bus.busy_o), 128'd0);
    check("abort_done", 128'(bus.done_o), 128'd0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_done", 128'(done_cnt - d0), 128'd0);
    check("abort_stays_idle", 128'(bus.busy_o), 128'd0);

    check("drain_256", 128'(exp_q.size()), 128'd0);
    check("drain_128", 128'(exp_q128.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
